// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
// Optional long-press detection is enabled with DEBOUNCE_HOLD_EN.
package debounce_pkg;

  // 10 ms debounce window and 2 s long-press at 24 MHz / 100 MHz
  localparam int unsigned DELAY_24MHZ  = 240_000;
  localparam int unsigned DELAY_100MHZ = 1_000_000;
  localparam int unsigned HOLD_24MHZ   = 48_000_000;
  localparam int unsigned HOLD_100MHZ  = 200_000_000;

  function automatic int unsigned cnt_w(input int unsigned delay);
    return (delay <= 32'd1) ? 32'd1 : 32'($clog2(delay));
  endfunction

  function automatic int unsigned hold_w(input int unsigned hold);
    return (hold < 32'd1) ? 32'd1 : 32'($clog2(hold + 32'd1));
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single debounce channel: synchroniser, stability counter, edge pulses and
// optional long-press pulse (DEBOUNCE_HOLD_EN).
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned DELAY       = DELAY_24MHZ,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0,
  parameter int unsigned HOLD_CYCLES = HOLD_24MHZ
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_in,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_hold
);

  localparam int unsigned      CNT_W    = cnt_w(DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 32'd1);

  if (SYNC_STAGES < 2 || DELAY < 1 || HOLD_CYCLES < 1) begin : g_param_err
    $error("debounce_chan: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;

  // Plain shift chain, no logic between stages
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any return to the current level restarts the stability window
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q  <= '0;
      o_out  <= IDLE_LEVEL;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      if (s == o_out) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q  <= '0;
        o_out  <= s;
        o_rise <= s;
        o_fall <= ~s;
      end
    end
  end

`ifdef DEBOUNCE_HOLD_EN
  localparam int unsigned       HOLD_W   = hold_w(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_q;

  // Saturating active-time counter; fires once per press
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hold_q <= '0;
      o_hold <= 1'b0;
    end else begin
      o_hold <= 1'b0;
      if (o_out == IDLE_LEVEL) begin
        hold_q <= '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_q <= hold_q + 1'b1;
        o_hold <= (hold_q == HOLD_MAX - 1'b1);
      end
    end
  end
`else
  assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// CHANNELS independent debouncers for board buttons and switches.
// Define DEBOUNCE_HOLD_EN to enable the per-channel long-press pulse on o_hold.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DELAY       = DELAY_24MHZ,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0,
  parameter int unsigned HOLD_CYCLES = HOLD_24MHZ
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [CHANNELS-1:0] i_in,
  output logic [CHANNELS-1:0] o_out,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_hold
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_chan #(
      .DELAY      (DELAY),
      .SYNC_STAGES(SYNC_STAGES),
      .IDLE_LEVEL (IDLE_LEVEL),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .i_clk (i_clk),
      .i_rstn(i_rstn),
      .i_in  (i_in[g]),
      .o_out (o_out[g]),
      .o_rise(o_rise[g]),
      .o_fall(o_fall[g]),
      .o_hold(o_hold[g])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: directed scenarios plus random bouncing,
// checked against a look-back window model of the acceptance rule.
module tb_debounce_multi;

  localparam int   CH   = 2;
  localparam int   DLY  = 8;
  localparam int   SYNC = 2;
  localparam int   HOLD = 20;
  localparam logic IDLE = 1'b0;
  localparam int   LAT  = SYNC + DLY;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic [CH-1:0] i_in = '0;
  logic [CH-1:0] o_out, o_rise, o_fall, o_hold;

  int checks = 0;
  int failures = 0;
  bit mon_stop = 1'b0;

  typedef struct packed {
    logic [CH-1:0] out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] hold;
  } exp_t;

  exp_t exp_q[$];

  // Model state: raw samples since reset, last acceptance edge, last activation edge
  int   en;
  int   last_acc  [CH];
  int   rise_edge [CH];
  logic m_out     [CH];
  logic samp      [CH][0:8191];

  debounce_multi #(
    .CHANNELS   (CH),
    .DELAY      (DLY),
    .SYNC_STAGES(SYNC),
    .IDLE_LEVEL (IDLE),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_in  (i_in),
    .o_out (o_out),
    .o_rise(o_rise),
    .o_fall(o_fall),
    .o_hold(o_hold)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Value the synchronised input presents at edge k (edge 1 = first after reset)
  function automatic logic s_at(input int ch, input int k);
    return (k <= SYNC) ? IDLE : samp[ch][k-SYNC];
  endfunction

  function automatic void model_reset();
    en = 0;
    for (int c = 0; c < CH; c++) begin
      m_out[c]     = IDLE;
      last_acc[c]  = 0;
      rise_edge[c] = -100000;
    end
    exp_q.delete();
  endfunction

  // A level is accepted once the synchronised input has differed from the
  // output on DLY consecutive edges, all after the previous acceptance.
  function automatic void model_edge(input logic [CH-1:0] v);
    exp_t e;
    logic ob, sv;
    bit   acc;
    e  = '0;
    en = en + 1;
    for (int c = 0; c < CH; c++) begin
      samp[c][en] = v[c];
      ob  = m_out[c];
      sv  = s_at(c, en);
      acc = (en - DLY + 1 > last_acc[c]);
      if (acc) begin
        for (int k = en - DLY + 1; k <= en; k++)
          if (s_at(c, k) == ob) acc = 1'b0;
      end
`ifdef DEBOUNCE_HOLD_EN
      if (ob != IDLE && en == rise_edge[c] + HOLD) e.hold[c] = 1'b1;
`endif
      if (acc) begin
        m_out[c]    = sv;
        last_acc[c] = en;
        e.rise[c]   = sv;
        e.fall[c]   = ~sv;
        if (sv != IDLE) rise_edge[c] = en;
      end
      e.out[c] = m_out[c];
    end
    exp_q.push_back(e);
  endfunction

  task automatic cmp(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive(input logic [CH-1:0] v);
    i_in = v;
    model_edge(v);
  endtask

  task automatic cycle(input logic [CH-1:0] v);
    @(negedge i_clk);
    drive(v);
  endtask

  // Edges from the input change until the expected pulse appears
  task automatic latency(input int ch, input logic val, input int req, input string nm);
    logic [CH-1:0] v;
    logic seen;
    int lat;
    v = i_in;
    v[ch] = val;
    cycle(v);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      seen = val ? o_rise[ch] : o_fall[ch];
      drive(v);
      if (seen) begin
        lat = k;
        break;
      end
    end
    chk_int(nm, lat, req);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #3;
    i_rstn = 1'b0;
    #1;
    cmp("rst_out", o_out, '0);
    cmp("rst_rise", o_rise, '0);
    cmp("rst_fall", o_fall, '0);
    cmp("rst_hold", o_hold, '0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    model_reset();
    drive(i_in);
  endtask

  // Monitor: one expectation per active clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (mon_stop) break;
      if (i_rstn) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          cmp("out", o_out, e.out);
          cmp("rise", o_rise, e.rise);
          cmp("fall", o_fall, e.fall);
          cmp("hold", o_hold, e.hold);
        end
      end
    end
  end

  initial begin
    logic [CH-1:0] v;
    int rem [CH];
    int r, hl;
    logic seen;

    model_reset();
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    drive('0);
    repeat (12) cycle('0);

    // Clean press on channel 0, then long-press timing
    latency(0, 1'b1, LAT, "press_lat");
    hl = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge i_clk);
      seen = o_hold[0];
      drive(i_in);
      if (seen) begin
        hl = k;
        break;
      end
    end
`ifdef DEBOUNCE_HOLD_EN
    chk_int("hold_lat", hl, HOLD);
`else
    chk_int("hold_lat", hl, -1);
`endif
    repeat (30) cycle(i_in);
    latency(0, 1'b0, LAT, "release_lat");
    repeat (12) cycle(i_in);

    // Bounce: toggles every 3 cycles, final toggle to 1
    for (int i = 0; i < 16; i++) begin
      v = i_in;
      v[0] = (i % 2 == 0);
      repeat (3) cycle(v);
    end
    latency(0, 1'b1, LAT, "bounce_lat");
    latency(0, 1'b0, LAT, "bounce_release_lat");
    repeat (12) cycle(i_in);

    // Channel 1 changed for DLY-1 sampled cycles only
    v = i_in;
    v[1] = 1'b1;
    repeat (DLY - 1) cycle(v);
    v[1] = 1'b0;
    repeat (15) cycle(v);
    chk_int("glitch_out1", int'(o_out[1]), 0);

    // Asynchronous reset with both inputs active
    repeat (LAT + 5) cycle(2'b11);
    cmp("pre_reset_out", o_out, 2'b11);
    do_reset();
    repeat (LAT + 10) cycle(2'b11);
    repeat (LAT + 5) cycle(2'b00);

    // Random bounce lengths, with periodic mid-stream resets
    for (int c = 0; c < CH; c++) rem[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 500) begin
        do_reset();
      end else begin
        v = i_in;
        for (int c = 0; c < CH; c++) begin
          if (rem[c] == 0) begin
            v[c] = ~v[c];
            r = int'($urandom_range(0, 9));
            if (r < 5)      rem[c] = int'($urandom_range(1, DLY - 1));
            else if (r < 8) rem[c] = int'($urandom_range(DLY, 20));
            else            rem[c] = int'($urandom_range(HOLD + 1, 45));
          end
          rem[c] = rem[c] - 1;
        end
        cycle(v);
      end
    end

    @(negedge i_clk);
    mon_stop = 1'b1;
    @(posedge i_clk);
    #2;
    chk_int("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel successor to the single-input button debouncer.
- Each channel:
  - synchronises an asynchronous input (button or switch);
  - filters bounce with a per-channel stability counter;
  - produces a clean level plus one-cycle rise/fall pulses.
- Sits between board pins and the camera control logic: capture trigger, mode select and register-reload buttons.

Parameters:
- CHANNELS, 4, number of independent inputs (>=1)
- DELAY, 240_000, consecutive clk cycles of stable, changed input needed to accept a new level (>=1)
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
- IDLE_LEVEL, 1'b0, reset/idle level of inputs, synchroniser and o_out (0 = active-high buttons)
- HOLD_CYCLES, 48_000_000, cycles o_out must stay at active level before o_hold fires (used only with DEBOUNCE_HOLD_EN)

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  asynchronous active-low reset
- i_in  in  CHANNELS  raw asynchronous inputs, one bit per channel
- o_out  out  CHANNELS  debounced level
- o_rise  out  CHANNELS  one-cycle pulse when o_out goes 0->1
- o_fall  out  CHANNELS  one-cycle pulse when o_out goes 1->0
- o_hold  out  CHANNELS  one-cycle long-press pulse (0 when feature compiled out)

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous, active-low (i_rstn), applied to every flop.
  - All channels are identical and fully independent.
- Reset values:
  - Synchroniser flops = IDLE_LEVEL; o_out = IDLE_LEVEL.
  - Counters = 0; o_rise = o_fall = o_hold = 0.
- Synchroniser: SYNC_STAGES flops in series; s = last stage; no logic between stages.
- Counter: width CNT_W = max(1, $clog2(DELAY)). Per clock edge:
  - s == o_out: count <= 0 (any bounce back restarts the window).
  - s != o_out and count < DELAY-1: count <= count+1.
  - s != o_out and count == DELAY-1: o_out <= s, count <= 0, and pulse on the same edge (o_rise if s=1, o_fall if s=0).
- Latency:
  - A clean input step reaches o_out exactly SYNC_STAGES + DELAY edges after the first edge that samples it.
  - DELAY=1 gives SYNC_STAGES + 1.
- Pulses:
  - o_rise and o_fall are registered, high exactly one cycle, and never both high in one channel.
  - They coincide with the o_out transition cycle.
- No wrap-around: the counter is cleared on acceptance, so it never exceeds DELAY-1.
- Boundary cases:
  - Input toggling faster than DELAY: o_out never changes.
  - Input returning to o_out on the edge where count == DELAY-1: takes the "s == o_out" branch, so there is no update and count clears.
- Reset mid-count: count is discarded and o_out returns to IDLE_LEVEL without a pulse. The first post-reset accepted change does pulse.
- Undefined (X) inputs are not treated specially; the synchroniser must not use case-equality.

Optional Feature:
- Macro: DEBOUNCE_HOLD_EN.
- Defined:
  - A per-channel hold counter of width $clog2(HOLD_CYCLES+1) counts cycles while o_out != IDLE_LEVEL.
  - When it reaches HOLD_CYCLES, o_hold pulses one cycle and the counter saturates; no repeat.
  - The counter clears when o_out returns to IDLE_LEVEL or on reset.
- Undefined: the hold counter is absent, and o_hold is tied to 0 (port retained).

Decomposition:
- Shared package/header debounce_pkg holds:
  - CNT_W computation function (max(1, clog2));
  - default DELAY/HOLD constants for 24 MHz and 100 MHz builds.
- One sub-module, debounce_chan:
  - single-channel synchroniser, counter, pulse and optional hold logic;
  - instantiated CHANNELS times via generate in debounce_multi.

Test Plan (CHANNELS=2, DELAY=8, SYNC_STAGES=2, IDLE_LEVEL=0, HOLD_CYCLES=20):
- Reset check: assert i_rstn=0 mid-simulation with i_in=2'b11 -> all outputs 0 immediately (async), no pulses after release until 10 stable cycles pass.
- Clean press: i_in[0] 0->1 held -> o_out[0]=1 and o_rise[0]=1 for one cycle exactly 10 edges after the first sampling edge; channel 1 unchanged.
- Bounce rejection: i_in[0] toggles every 3 cycles for 50 cycles, then stays 1 -> o_out[0] rises exactly 10 edges after the final toggle; no earlier pulse.
- Release: after the press, i_in[0]=0 held -> o_fall[0] one cycle, o_out[0]=0, 10 edges after the change.
- Last-cycle glitch: i_in[1]=1 for exactly 7 sampled cycles, then 0 -> no o_out[1] change, counter back to 0.
- With DEBOUNCE_HOLD_EN: hold i_in[0]=1 -> o_hold[0] pulses once 20 cycles after o_out[0] rose, then stays 0 while held. Without the macro -> o_hold stays 0.
